// File: rtl/xif_offload_tracker.sv
// xif_offload_tracker
//
// In-flight tracker for X-interface offloads. Every accepted issue is recorded in issue order
// in a circular buffer. Commit/kill events and out-of-order backend results are paired with
// their entries by id (CAM). Results are returned to the core strictly in issue order, and
// only once the entry is both committed and holds its backend result. Killed entries retire
// silently.
//
// Parameters:
//   X_ID_WIDTH  - instruction id width
//   X_RFW_WIDTH - result data width (multiple of XLEN)
//   XLEN        - integer register width
//   DEPTH       - maximum in-flight offloads, power of two in 2..16
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   issue_*_i                     - observed issue handshake and response (id, rd, writeback)
//   issue_stall_o                 - equals full_o; the backend gates issue_ready with it
//   commit_valid_i/id_i/kill_i    - commit or kill strobe
//   res_valid_i/id_i/data_i       - backend result strobe (no backpressure)
//   result_*_o, result_ready_i    - in-order result channel to the core
//   count_o, full_o, empty_o      - occupancy
//   err_o                         - one-cycle protocol error pulse
//   late_drop_o                   - one-cycle pulse when a result matched no entry

module xif_offload_tracker #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    // Issue channel
    input  logic                              issue_valid_i,
    input  logic                              issue_ready_i,
    input  logic                              issue_accept_i,
    input  logic                              issue_writeback_i,
    input  logic [X_ID_WIDTH-1:0]             issue_id_i,
    input  logic [4:0]                        issue_rd_i,
    output logic                              issue_stall_o,
    // Commit channel
    input  logic                              commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]             commit_id_i,
    input  logic                              commit_kill_i,
    // Backend results
    input  logic                              res_valid_i,
    input  logic [X_ID_WIDTH-1:0]             res_id_i,
    input  logic [X_RFW_WIDTH-1:0]            res_data_i,
    // Result channel to the core
    output logic                              result_valid_o,
    input  logic                              result_ready_i,
    output logic [X_ID_WIDTH-1:0]             result_id_o,
    output logic [X_RFW_WIDTH-1:0]            result_data_o,
    output logic [4:0]                        result_rd_o,
    output logic [X_RFW_WIDTH/XLEN-1:0]       result_we_o,
    // Status
    output logic [$clog2(DEPTH):0]            count_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic                              err_o,
    output logic                              late_drop_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned WeW  = X_RFW_WIDTH / XLEN;

    // Pointers carry one extra wrap bit above the index.
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;

    // Per-entry control flags
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wb_q, wb_d;
    logic [DEPTH-1:0] committed_q, committed_d;
    logic [DEPTH-1:0] killed_q, killed_d;
    logic [DEPTH-1:0] has_res_q, has_res_d;

    // Per-entry payload; only meaningful while the entry is valid, so left unreset.
    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_d   [DEPTH];
    logic [4:0]             rd_q   [DEPTH];
    logic [4:0]             rd_d   [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_d [DEPTH];

    logic err_q, err_d;
    logic late_drop_q, late_drop_d;

    logic [IdxW-1:0] head_idx;
    logic [IdxW-1:0] tail_idx;
    logic            full;
    logic            head_valid;
    logic            head_ready;
    logic            retire_kill;
    logic            retire;
    logic            issue_fire;
    logic            alloc;

    logic            commit_hit;
    logic [IdxW-1:0] commit_sel;
    logic            res_hit;
    logic [IdxW-1:0] res_sel;
    logic            dup_hit;

    assign head_idx = head_q[IdxW-1:0];
    assign tail_idx = tail_q[IdxW-1:0];

    // Full when the indices coincide but the wrap bits differ.
    assign full = (head_idx == tail_idx) && (head_q[IdxW] != tail_q[IdxW]);

    assign head_valid  = valid_q[head_idx];
    assign head_ready  = head_valid && committed_q[head_idx] && has_res_q[head_idx]
                         && !killed_q[head_idx];
    assign retire_kill = head_valid && killed_q[head_idx];
    assign retire      = retire_kill || (head_ready && result_ready_i);

    assign issue_fire = issue_valid_i && issue_ready_i && issue_accept_i;
    assign alloc      = issue_fire && !full;

    // CAM lookups. Duplicate ids are legal (with an error pulse), so the search walks from
    // head towards tail and takes the oldest matching entry.
    always_comb begin
        commit_hit = 1'b0;
        commit_sel = '0;
        res_hit    = 1'b0;
        res_sel    = '0;
        dup_hit    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!commit_hit && valid_q[head_idx + IdxW'(i)]
                && (id_q[head_idx + IdxW'(i)] == commit_id_i)) begin
                commit_hit = 1'b1;
                commit_sel = head_idx + IdxW'(i);
            end
            if (!res_hit && valid_q[head_idx + IdxW'(i)] && !killed_q[head_idx + IdxW'(i)]
                && (id_q[head_idx + IdxW'(i)] == res_id_i)) begin
                res_hit = 1'b1;
                res_sel = head_idx + IdxW'(i);
            end
            if (valid_q[i[IdxW-1:0]] && (id_q[i[IdxW-1:0]] == issue_id_i)) begin
                dup_hit = 1'b1;
            end
        end
    end

    // Next-state for the buffer. Commit and result updates are independent so an entry can
    // take both in one cycle; retire (head) and allocate (tail) never touch the same slot
    // because retire needs a valid head and allocate needs a non-full buffer.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        valid_d     = valid_q;
        wb_d        = wb_q;
        committed_d = committed_q;
        killed_d    = killed_q;
        has_res_d   = has_res_q;
        id_d        = id_q;
        rd_d        = rd_q;
        data_d      = data_q;

        // A repeat commit just re-sets committed; a kill always wins.
        if (commit_valid_i && commit_hit) begin
            committed_d[commit_sel] = 1'b1;
            if (commit_kill_i) begin
                killed_d[commit_sel] = 1'b1;
            end
        end

        if (res_valid_i && res_hit) begin
            data_d[res_sel]    = res_data_i;
            has_res_d[res_sel] = 1'b1;
        end

        if (retire) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PtrW'(1);
        end

        if (alloc) begin
            valid_d[tail_idx]     = 1'b1;
            wb_d[tail_idx]        = issue_writeback_i;
            committed_d[tail_idx] = 1'b0;
            killed_d[tail_idx]    = 1'b0;
            has_res_d[tail_idx]   = 1'b0;
            id_d[tail_idx]        = issue_id_i;
            rd_d[tail_idx]        = issue_rd_i;
            tail_d                = tail_q + PtrW'(1);
        end
    end

    // Errors: issue while full (blocked), duplicate-id issue (still allocated), commit miss.
    assign err_d       = (issue_fire && full) || (alloc && dup_hit)
                         || (commit_valid_i && !commit_hit);
    assign late_drop_d = res_valid_i && !res_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            wb_q        <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            has_res_q   <= '0;
            err_q       <= 1'b0;
            late_drop_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            valid_q     <= valid_d;
            wb_q        <= wb_d;
            committed_q <= committed_d;
            killed_q    <= killed_d;
            has_res_q   <= has_res_d;
            err_q       <= err_d;
            late_drop_q <= late_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        id_q   <= id_d;
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    // Result outputs come straight from registered head state and are zeroed when idle.
    assign result_valid_o = head_ready;
    assign result_id_o    = head_ready ? id_q[head_idx]   : '0;
    assign result_data_o  = head_ready ? data_q[head_idx] : '0;
    assign result_rd_o    = head_ready ? rd_q[head_idx]   : '0;
    assign result_we_o    = {WeW{head_ready && wb_q[head_idx]}};

    assign count_o       = tail_q - head_q;
    assign full_o        = full;
    assign empty_o       = (head_q == tail_q);
    assign issue_stall_o = full;
    assign err_o         = err_q;
    assign late_drop_o   = late_drop_q;

endmodule

// File: doc/xif_offload_tracker.md
# xif_offload_tracker

Parametrised in-flight tracker for the X-interface coprocessor path. It sits between the core's issue/commit/result channels and the vector backend. It records every accepted offload in issue order and pairs commit/kill events and out-of-order backend results with their entries. Results are returned to the core strictly in issue order, only after commit; killed entries retire silently.

## Interface
Parameters:
- X_ID_WIDTH, 4, instruction id width; matches X-IF package.
- X_RFW_WIDTH, 32, result data width.
- XLEN, 32, integer register width; X_RFW_WIDTH must be a multiple of XLEN.
- DEPTH, 8, maximum in-flight offloads; power of two, 2..16.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid_i  in  1  core issue valid.
- issue_ready_i  in  1  coprocessor issue ready (observed).
- issue_accept_i  in  1  issue response accept.
- issue_writeback_i  in  1  issue response writeback.
- issue_id_i  in  X_ID_WIDTH  issued id.
- issue_rd_i  in  5  destination register.
- issue_stall_o  out  1  =full_o; the backend must gate issue_ready with it.
- commit_valid_i  in  1  commit strobe.
- commit_id_i  in  X_ID_WIDTH  committed id.
- commit_kill_i  in  1  kill instead of commit.
- res_valid_i  in  1  backend result strobe; no backpressure.
- res_id_i  in  X_ID_WIDTH  backend result id.
- res_data_i  in  X_RFW_WIDTH  backend result data.
- result_valid_o  out  1  result to core valid.
- result_ready_i  in  1  core result ready.
- result_id_o  out  X_ID_WIDTH  head id.
- result_data_o  out  X_RFW_WIDTH  head data.
- result_rd_o  out  5  head rd.
- result_we_o  out  X_RFW_WIDTH/XLEN  all-ones if writeback else zero.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- full_o, empty_o  out  1  occupancy flags.
- err_o  out  1  one-cycle protocol error pulse.
- late_drop_o  out  1  one-cycle pulse: result with no matching entry dropped.

## Operation
- Storage: circular buffer of DEPTH entries with head/tail pointers of $clog2(DEPTH)+1 bits (the extra bit is the wrap flag). Fields per entry: valid, id, rd, wb, committed, killed, has_res, data.
- Allocate when issue_valid_i & issue_ready_i & issue_accept_i & !full_o. Write the entry at tail with committed=killed=has_res=0, then tail+1.
- Allocation attempt while full_o is blocked and pulses err_o. Issue whose id matches a valid entry is allocated anyway and pulses err_o.
- Commit: CAM match of commit_id_i against valid entries. A match sets committed=1, plus killed=1 if commit_kill_i. No match pulses err_o. A repeat commit on a committed entry is ignored.
- Backend result: CAM match of res_id_i against valid, not-killed entries. A match stores data and sets has_res=1. No match discards the result and pulses late_drop_o.
- Head retire:
  - killed head: retires without handshake in the cycle it is seen killed.
  - committed & has_res head: result_valid_o=1; retires on result_valid_o & result_ready_i.
  - otherwise head waits.
- Only one retire per cycle. Allocate and retire in the same cycle give count_o unchanged.
- An entry receiving a result and a commit in the same cycle takes both updates.
- A kill arriving while that entry is presented with result_valid_o=1 and result_ready_i=0 drops valid next cycle. This is the only permitted valid withdrawal.

## Timing
- Reset: head=tail=0; all entry valid=0. Outputs after reset: result_valid_o=0, result_id_o=0, result_data_o=0, result_rd_o=0, result_we_o=0, count_o=0, empty_o=1, full_o=0, issue_stall_o=0, err_o=0, late_drop_o=0.
- Reset mid-operation discards all entries with no result emitted.
- Result outputs are driven from registered head state.
- Minimum latency: last of (commit, result) at edge N gives result_valid_o high during cycle N+1.
- full_o/count_o reflect state after the previous edge. A retire in cycle N does not unblock allocation until N+1.
- err_o/late_drop_o are registered and pulse in the cycle after the offending event.
- Pointer wrap: index uses the low bits; full when indices are equal and wrap bits differ.

## Test plan
- Single offload: issue id 3 rd 5 wb=1, commit at cycle 2, result 0xDEADBEEF at cycle 4 → result_valid_o at cycle 5 with id 3, rd 5, data 0xDEADBEEF, we all-ones; count_o returns to 0.
- Out-of-order results: issue ids 1, 2, 3; results arrive 3, 1, 2; all committed → outputs emitted in order 1, 2, 3.
- Kill: issue ids 4, 5; kill 4; commit 5 with result → id 4 never appears; id 5 emitted. A later result for id 4 pulses late_drop_o once.
- Full/wrap: issue DEPTH offloads → full_o=1, issue_stall_o=1. An extra issue pulses err_o and is not allocated. Drain all, then refill across the wrap → order preserved.
- Backpressure: hold result_ready_i=0 for 5 cycles → result_valid_o and data held stable; retire on the first ready cycle.
- Errors: commit of unknown id 9 → err_o pulse. Duplicate issue id → err_o pulse. Reset asserted with 3 entries → empty_o=1 next cycle and no result emitted.
